// File: rtl/seq_alu_if.sv
// Request/response bundle between a controller and seq_alu.
// The controller drives the master side and the ALU drives the slave side.
interface seq_alu_if #(
  parameter int N = 8
);
  logic         start;
  logic [3:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] o;
  logic [N-1:0] o_hi;
  logic         of;
  logic         uf;
  logic         err;
  logic         zero;

  modport master (
    output start, op, a, b,
    input  busy, done, o, o_hi, of, uf, err, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, o, o_hi, of, uf, err, zero
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/shift/compare, N-step shift-add multiply and,
// when SEQ_ALU_DIV_EN is defined, an N-step restoring divide. start/done handshake.
module seq_alu #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst,
  seq_alu_if.slave   bus
);

  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0] NB = N'(N);

  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_SHL = 4'h2, OP_SHR = 4'h3,
    OP_EQ  = 4'h4, OP_GT  = 4'h5, OP_LT  = 4'h6, OP_MUL = 4'h7,
    OP_DIV = 4'h8
  } op_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [3:0]    opr;
  logic [N-1:0]  ra, rb;
  logic [N-1:0]  hi, lo, hi_n, lo_n;
  logic [N:0]    mul_sum;
  logic          start_multi;

  logic [N-1:0]  r_o, r_hi;
  logic          r_of, r_uf, r_err, r_zero;

  logic [N-1:0]  o_q, o_hi_q;
  logic          of_q, uf_q, err_q, zero_q, done_q;

`ifdef SEQ_ALU_DIV_EN
  logic [N:0]    div_sh;
  logic [N+1:0]  div_diff;
`endif

  always_comb begin
    state_n = state;
`ifdef SEQ_ALU_DIV_EN
    start_multi = (bus.op == OP_MUL) || (bus.op == OP_DIV);
`else
    start_multi = (bus.op == OP_MUL);
`endif
    case (state)
      IDLE:    if (bus.start) state_n = start_multi ? ITER : FIN;
      ITER:    if (cnt == CW'(1)) state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // hi:lo doubles as product accumulator:multiplier (MUL) and remainder:quotient (DIV)
  always_comb begin
    hi_n    = hi;
    lo_n    = lo;
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, ra} : '0);
`ifdef SEQ_ALU_DIV_EN
    div_sh   = {hi, lo[N-1]};
    div_diff = {1'b0, div_sh} - {2'b00, rb};
`endif
    if (opr == OP_MUL) begin
      hi_n = mul_sum[N:1];
      lo_n = {mul_sum[0], lo[N-1:1]};
    end
`ifdef SEQ_ALU_DIV_EN
    else if (!div_diff[N+1]) begin
      hi_n = div_diff[N-1:0];
      lo_n = {lo[N-2:0], 1'b1};
    end else begin
      hi_n = div_sh[N-1:0];
      lo_n = {lo[N-2:0], 1'b0};
    end
`endif
  end

  always_comb begin
    r_o    = '0;
    r_hi   = '0;
    r_of   = 1'b0;
    r_uf   = 1'b0;
    r_err  = 1'b0;
    r_zero = 1'b0;
    case (opr)
      OP_ADD: {r_of, r_o} = {1'b0, ra} + {1'b0, rb};
      OP_SUB: begin
        r_o  = ra - rb;
        r_uf = (ra < rb);
      end
      OP_SHL: r_o = (rb >= NB) ? '0 : (ra << rb);
      OP_SHR: r_o = (rb >= NB) ? '0 : (ra >> rb);
      OP_EQ:  r_zero = (ra == rb);
      OP_GT:  r_zero = (ra > rb);
      OP_LT:  r_zero = (ra < rb);
      OP_MUL: begin
        r_o  = lo;
        r_hi = hi;
        r_of = |hi;
      end
`ifdef SEQ_ALU_DIV_EN
      // restoring division by zero naturally leaves quotient all ones, remainder a
      OP_DIV: begin
        r_o   = lo;
        r_hi  = hi;
        r_err = (rb == '0);
      end
`endif
      default: r_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      opr    <= '0;
      ra     <= '0;
      rb     <= '0;
      hi     <= '0;
      lo     <= '0;
      o_q    <= '0;
      o_hi_q <= '0;
      of_q   <= 1'b0;
      uf_q   <= 1'b0;
      err_q  <= 1'b0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          opr <= bus.op;
          ra  <= bus.a;
          rb  <= bus.b;
          cnt <= CW'(N);
          hi  <= '0;
          lo  <= (bus.op == OP_MUL) ? bus.b : bus.a;
        end
        ITER: begin
          cnt <= cnt - 1'b1;
          hi  <= hi_n;
          lo  <= lo_n;
        end
        FIN: begin
          o_q    <= r_o;
          o_hi_q <= r_hi;
          of_q   <= r_of;
          uf_q   <= r_uf;
          err_q  <= r_err;
          zero_q <= r_zero;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.o    = o_q;
  assign bus.o_hi = o_hi_q;
  assign bus.of   = of_q;
  assign bus.uf   = uf_q;
  assign bus.err  = err_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: arithmetic reference model plus per-cycle compare of all outputs,
// directed literal cases, a mid-operation reset and randomized traffic.
module tb_seq_alu;
  localparam int N = 8;

  typedef struct {
    logic [N-1:0] o;
    logic [N-1:0] hi;
    logic         of, uf, err, zero;
    int           lat;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   nchk = 0;
  int   nfail = 0;
  int   ndone = 0;
  bit   chk_en = 1'b0;

  bit   pend = 1'b0;
  int   pend_t, pend_done;
  int   last_done = -1;
  res_t pend_res, cur;

  seq_alu_if #(.N(N)) bus ();
  seq_alu #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic res_t model(input int unsigned op, input int unsigned a, input int unsigned b);
    res_t r;
    int unsigned m = 1 << N;
    int unsigned p;
    r.o = '0; r.hi = '0; r.of = 0; r.uf = 0; r.err = 0; r.zero = 0; r.lat = 1;
    case (op)
      0: begin r.o = N'((a + b) % m); r.of = (a + b) >= m; end
      1: begin r.o = N'((a + m - b) % m); r.uf = a < b; end
      2: r.o = (b >= N) ? '0 : N'((a << b) % m);
      3: r.o = (b >= N) ? '0 : N'(a >> b);
      4: r.zero = (a == b);
      5: r.zero = (a > b);
      6: r.zero = (a < b);
      7: begin
        p = a * b;
        r.o = N'(p % m); r.hi = N'(p / m); r.of = (p / m) != 0; r.lat = N + 1;
      end
`ifdef SEQ_ALU_DIV_EN
      8: begin
        r.lat = N + 1;
        if (b == 0) begin r.err = 1; r.o = N'(m - 1); r.hi = N'(a); end
        else begin r.o = N'(a / b); r.hi = N'(a % b); end
      end
`endif
      default: r.err = 1;
    endcase
    return r;
  endfunction

  // Called while start is driven for the upcoming edge cyc+1.
  task automatic issue(input int unsigned op, input int unsigned a, input int unsigned b);
    int k = cyc + 1;
    if (k > last_done) begin
      pend_res  = model(op, a, b);
      pend      = 1'b1;
      pend_t    = k;
      pend_done = k + pend_res.lat;
      last_done = pend_done;
    end
  endtask

  task automatic model_reset();
    pend = 1'b0;
    last_done = -1;
    cur.o = '0; cur.hi = '0; cur.of = 0; cur.uf = 0; cur.err = 0; cur.zero = 0; cur.lat = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit eb, ed;
      eb = pend && (cyc >= pend_t) && (cyc < pend_done);
      ed = pend && (cyc == pend_done);
      if (ed) begin
        cur  = pend_res;
        pend = 1'b0;
      end
      chk("busy", 32'(bus.busy), 32'(eb));
      chk("done", 32'(bus.done), 32'(ed));
      chk("o",    32'(bus.o),    32'(cur.o));
      chk("o_hi", 32'(bus.o_hi), 32'(cur.hi));
      chk("of",   32'(bus.of),   32'(cur.of));
      chk("uf",   32'(bus.uf),   32'(cur.uf));
      chk("err",  32'(bus.err),  32'(cur.err));
      chk("zero", 32'(bus.zero), 32'(cur.zero));
      if (bus.done === 1'b1) ndone++;
    end
  end

  task automatic txn(input logic [3:0] op, input int unsigned a, input int unsigned b,
                     input logic [N-1:0] eo, input logic [N-1:0] ehi,
                     input logic eof, input logic euf, input logic eerr, input logic ez,
                     input int elat, input int pulse_at);
    int t, d0;
    bit seen = 1'b0;
    @(negedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.a = N'(a); bus.b = N'(b);
    issue(op, a, b);
    t  = cyc + 1;
    d0 = ndone;
    @(negedge clk); #1;
    bus.start = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      if (i == pulse_at) begin
        bus.start = 1'b1; bus.op = 4'd0; bus.a = 1; bus.b = 1;
        issue(0, 1, 1);
      end else bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    bus.start = 1'b0;
    chk("txn_timeout", 32'(seen), 32'd1);
    if (seen) begin
      chk("txn_latency", 32'(cyc - t), 32'(elat));
      chk("txn_o",    32'(bus.o),    32'(eo));
      chk("txn_o_hi", 32'(bus.o_hi), 32'(ehi));
      chk("txn_of",   32'(bus.of),   32'(eof));
      chk("txn_uf",   32'(bus.uf),   32'(euf));
      chk("txn_err",  32'(bus.err),  32'(eerr));
      chk("txn_zero", 32'(bus.zero), 32'(ez));
    end
    @(negedge clk); #1;
    chk("txn_done_count", 32'(ndone - d0), 32'd1);
  endtask

  initial begin
    int t, d0;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    model_reset();
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_o",    32'(bus.o),    32'd0);
    chk("rst_err",  32'(bus.err),  32'd0);

    txn(4'd0, 200, 100,  8'd44,  8'd0, 1, 0, 0, 0, 1, 0);
    txn(4'd1, 3, 5,      8'd254, 8'd0, 0, 1, 0, 0, 1, 0);
    txn(4'd4, 9, 9,      8'd0,   8'd0, 0, 0, 0, 1, 1, 0);
    txn(4'd2, 1, 9,      8'd0,   8'd0, 0, 0, 0, 0, 1, 0);
    txn(4'd3, 128, 3,    8'd16,  8'd0, 0, 0, 0, 0, 1, 0);
    txn(4'd5, 5, 3,      8'd0,   8'd0, 0, 0, 0, 1, 1, 0);
    txn(4'd6, 5, 3,      8'd0,   8'd0, 0, 0, 0, 0, 1, 0);
    txn(4'd7, 13, 11,    8'd143, 8'd0, 0, 0, 0, 0, 9, 0);
    txn(4'd7, 200, 3,    8'd88,  8'd2, 1, 0, 0, 0, 9, 3);
`ifdef SEQ_ALU_DIV_EN
    txn(4'd8, 100, 7,    8'd14,  8'd2, 0, 0, 0, 0, 9, 0);
    txn(4'd8, 5, 0,      8'd255, 8'd5, 0, 0, 1, 0, 9, 0);
`else
    txn(4'd8, 100, 7,    8'd0,   8'd0, 0, 0, 1, 0, 1, 0);
`endif
    txn(4'd15, 1, 2,     8'd0,   8'd0, 0, 0, 1, 0, 1, 0);

    // reset four edges into a multiply
    @(negedge clk); #1;
    bus.start = 1'b1; bus.op = 4'd7; bus.a = 8'd13; bus.b = 8'd11;
    issue(7, 13, 11);
    t = cyc + 1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    while (cyc < t + 3) begin @(negedge clk); #1; end
    rst = 1'b1;
    model_reset();
    d0 = ndone;
    @(posedge clk); #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_o",    32'(bus.o),    32'd0);
    chk("abort_o_hi", 32'(bus.o_hi), 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    chk("abort_no_done", 32'(ndone - d0), 32'd0);
    txn(4'd0, 1, 1,      8'd2,   8'd0, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      int unsigned r, op, a, b;
      @(negedge clk); #1;
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1; bus.start = 1'b0;
        model_reset();
      end else begin
        rst = 1'b0;
        r  = $urandom_range(0, 9);
        op = (r <= 2) ? 7 : (r == 3) ? 8 : $urandom_range(0, 15);
        a  = $urandom_range(0, 255);
        r  = $urandom_range(0, 5);
        b  = (r == 0) ? 0 : (r == 1) ? $urandom_range(0, 12) : $urandom_range(0, 255);
        bus.op = 4'(op); bus.a = N'(a); bus.b = N'(b);
        bus.start = ($urandom_range(0, 2) == 0);
        if (bus.start) issue(op, a, b);
      end
    end
    @(negedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    repeat (N + 4) @(negedge clk);
    #1;
    chk("drain_idle", 32'(pend), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
